cpu7_excp_ctl: RTL and testbench

//  Exception/ERTN sequencer between the EXE stage and the CSR file. Collects exception requests for
//  the instruction in E, picks one by fixed priority and issues a one-cycle commit pulse that drives
//  the CSR exception update (CRMD->PRMD save, ERA<=pc). It also drives the ERTN restore.
//  It then flushes the pipeline for a fixed number of cycles and hands a redirect PC (EENTRY or ERA)
//  to the IFU over a valid/ready handshake.

---
 rtl/cpu7_excp_ctl_pkg.sv | 23 ++
 rtl/cpu7_excp_ctl_prio.sv | 29 ++
 rtl/cpu7_excp_ctl.sv | 126 ++++++++++++
 tb/tb_cpu7_excp_ctl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu7_excp_ctl_pkg.sv
// Shared constants and types for the exception/ERTN sequencer.
// Ecodes follow the LoongArch CSR.ESTAT encoding.
package cpu7_excp_ctl_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } excp_state_t;

    // Selects the redirect source: EENTRY for exceptions, ERA for ERTN.
    typedef enum logic {
        KIND_EXC = 1'b0,
        KIND_RET = 1'b1
    } excp_kind_t;

endpackage

// File: rtl/cpu7_excp_ctl_prio.sv
// Fixed-priority exception selector: INT > INE > SYS > BRK > ALE.
// Requests arrive already qualified by valid_e.
module cpu7_excp_ctl_prio
    import cpu7_excp_ctl_pkg::*;
(
    input  logic       req_int,
    input  logic       req_ine,
    input  logic       req_sys,
    input  logic       req_brk,
    input  logic       req_ale,
    output logic       hit,
    output logic [5:0] ecode
);

    always_comb begin
        hit   = req_int | req_ine | req_sys | req_brk | req_ale;
        ecode = ECODE_ALE;
        if (req_int) begin
            ecode = ECODE_INT;
        end else if (req_ine) begin
            ecode = ECODE_INE;
        end else if (req_sys) begin
            ecode = ECODE_SYS;
        end else if (req_brk) begin
            ecode = ECODE_BRK;
        end
    end

endmodule

// File: rtl/cpu7_excp_ctl.sv
// Exception/ERTN sequencer: commits one request to the CSR file, flushes the
// pipeline for FLUSH_CYC cycles, then hands a redirect PC to the IFU.
module cpu7_excp_ctl
    import cpu7_excp_ctl_pkg::*;
#(
    parameter int GRLEN     = 32,
    parameter int FLUSH_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_e,
    input  logic [GRLEN-1:0] ifu_exu_pc_e,
    input  logic             excp_ale_e,
    input  logic             excp_sys_e,
    input  logic             excp_brk_e,
    input  logic             excp_ine_e,
    input  logic             int_pending,
    input  logic             crmd_ie,
    input  logic             ertn_e,
    input  logic [GRLEN-1:0] csr_eentry,
    input  logic [GRLEN-1:0] csr_era,
    input  logic             redirect_ready,
    output logic             excp_commit,
    output logic [5:0]       excp_ecode,
    output logic [GRLEN-1:0] excp_pc,
    output logic             ertn_commit,
    output logic             flush,
    output logic             redirect_valid,
    output logic [GRLEN-1:0] redirect_pc,
    output logic             busy
);

    localparam logic [3:0] CNT_LAST = 4'(FLUSH_CYC - 1);

    excp_state_t state, state_n;
    excp_kind_t  kind, kind_n;
    logic [3:0]  cnt, cnt_n;
    logic        hit, erq;
    logic [5:0]  hit_ecode;
    logic        take_exc, take_ret, load_redir;

    cpu7_excp_ctl_prio u_prio (
        .req_int (valid_e & int_pending & crmd_ie),
        .req_ine (valid_e & excp_ine_e),
        .req_sys (valid_e & excp_sys_e),
        .req_brk (valid_e & excp_brk_e),
        .req_ale (valid_e & excp_ale_e),
        .hit     (hit),
        .ecode   (hit_ecode)
    );

    // An exception on the same instruction always wins over ERTN.
    assign erq = valid_e & ertn_e & ~hit;

    always_comb begin
        state_n    = state;
        kind_n     = kind;
        cnt_n      = cnt;
        take_exc   = 1'b0;
        take_ret   = 1'b0;
        load_redir = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hit) begin
                    take_exc = 1'b1;
                    kind_n   = KIND_EXC;
                    cnt_n    = 4'd0;
                    state_n  = ST_FLUSH;
                end else if (erq) begin
                    take_ret = 1'b1;
                    kind_n   = KIND_RET;
                    cnt_n    = 4'd0;
                    state_n  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // The CSR update from the commit cycle is visible by the last flush cycle.
                if (cnt == CNT_LAST) begin
                    load_redir = 1'b1;
                    state_n    = ST_REDIR;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            ST_REDIR: begin
                if (redirect_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            kind        <= KIND_EXC;
            cnt         <= 4'd0;
            excp_commit <= 1'b0;
            ertn_commit <= 1'b0;
            excp_ecode  <= 6'd0;
            excp_pc     <= '0;
            redirect_pc <= '0;
        end else begin
            state       <= state_n;
            kind        <= kind_n;
            cnt         <= cnt_n;
            excp_commit <= take_exc;
            ertn_commit <= take_ret;
            if (take_exc) begin
                excp_ecode <= hit_ecode;
                excp_pc    <= ifu_exu_pc_e;
            end
            if (load_redir) begin
                redirect_pc <= (kind == KIND_EXC) ? csr_eentry : csr_era;
            end
        end
    end

    // redirect_valid/redirect_ready: the PC is offered and held stable while
    // redirect_valid is high; the transfer happens on a cycle where both are high.
    assign flush          = (state == ST_FLUSH);
    assign redirect_valid = (state == ST_REDIR);
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_cpu7_excp_ctl.sv
// Bench for cpu7_excp_ctl: directed scenarios plus random traffic checked
// against a timeline model of the sequencer.
module tb_cpu7_excp_ctl;

    parameter int FLUSH_CYC = 2;
    localparam int GRLEN = 32;
    localparam int CW = 1 + 6 + GRLEN + 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid_e;
    logic [GRLEN-1:0] ifu_exu_pc_e;
    logic             excp_ale_e, excp_sys_e, excp_brk_e, excp_ine_e;
    logic             int_pending, crmd_ie, ertn_e;
    logic [GRLEN-1:0] csr_eentry, csr_era;
    logic             redirect_ready;
    logic             excp_commit, ertn_commit, flush, redirect_valid, busy;
    logic [5:0]       excp_ecode;
    logic [GRLEN-1:0] excp_pc, redirect_pc;

    cpu7_excp_ctl #(.GRLEN(GRLEN), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_e        (valid_e),
        .ifu_exu_pc_e   (ifu_exu_pc_e),
        .excp_ale_e     (excp_ale_e),
        .excp_sys_e     (excp_sys_e),
        .excp_brk_e     (excp_brk_e),
        .excp_ine_e     (excp_ine_e),
        .int_pending    (int_pending),
        .crmd_ie        (crmd_ie),
        .ertn_e         (ertn_e),
        .csr_eentry     (csr_eentry),
        .csr_era        (csr_era),
        .redirect_ready (redirect_ready),
        .excp_commit    (excp_commit),
        .excp_ecode     (excp_ecode),
        .excp_pc        (excp_pc),
        .ertn_commit    (ertn_commit),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [CW-1:0]    exp_q[$];
    logic [GRLEN-1:0] redir_q[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // One request is in flight at a time; trigger cycle m_t fixes every later event.
    bit               m_busy = 0;
    int               m_t    = 0;
    bit               m_ret  = 0;
    logic [5:0]       m_ecode = '0;
    logic [GRLEN-1:0] m_pc    = '0;
    logic [GRLEN-1:0] m_rpc   = '0;

    function automatic int ref_ecode(bit i, bit ine, bit sys, bit brk, bit ale);
        if (i)   return 'h00;
        if (ine) return 'h0D;
        if (sys) return 'h0B;
        if (brk) return 'h0C;
        if (ale) return 'h09;
        return -1;
    endfunction

    always @(posedge clk) begin
        int ec;
        if (reset) begin
            m_busy  = 0;
            m_ecode = '0;
            m_pc    = '0;
            m_rpc   = '0;
            exp_q.delete();
            redir_q.delete();
        end else if (m_busy) begin
            if (cyc == m_t + FLUSH_CYC) begin
                m_rpc = m_ret ? csr_era : csr_eentry;
                redir_q.push_back(m_rpc);
            end
            if (cyc >= m_t + FLUSH_CYC + 1 && redirect_ready) m_busy = 0;
        end else if (valid_e) begin
            ec = ref_ecode(int_pending && crmd_ie, excp_ine_e, excp_sys_e, excp_brk_e, excp_ale_e);
            if (ec >= 0) begin
                m_busy  = 1;
                m_t     = cyc;
                m_ret   = 0;
                m_ecode = ec[5:0];
                m_pc    = ifu_exu_pc_e;
                exp_q.push_back({1'b0, m_ecode, m_pc, 32'(cyc + 1)});
            end else if (ertn_e) begin
                m_busy = 1;
                m_t    = cyc;
                m_ret  = 1;
                exp_q.push_back({1'b1, m_ecode, m_pc, 32'(cyc + 1)});
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        bit e_flush, e_rv, e_xc, e_rc;
        logic [CW-1:0] e;
        e_flush = m_busy && cyc >= m_t + 1 && cyc <= m_t + FLUSH_CYC;
        e_rv    = m_busy && cyc >= m_t + FLUSH_CYC + 1;
        e_xc    = m_busy && cyc == m_t + 1 && !m_ret;
        e_rc    = m_busy && cyc == m_t + 1 && m_ret;
        chk("flush", 80'(flush), 80'(e_flush));
        chk("redirect_valid", 80'(redirect_valid), 80'(e_rv));
        chk("busy", 80'(busy), 80'(m_busy));
        chk("excp_commit", 80'(excp_commit), 80'(e_xc));
        chk("ertn_commit", 80'(ertn_commit), 80'(e_rc));
        chk("excp_ecode", 80'(excp_ecode), 80'(m_ecode));
        chk("excp_pc", 80'(excp_pc), 80'(m_pc));
        chk("redirect_pc", 80'(redirect_pc), 80'(m_rpc));
        if (excp_commit || ertn_commit) begin
            if (exp_q.size() == 0) begin
                chk("commit_unexpected", 80'(1), 80'(0));
            end else begin
                e = exp_q.pop_front();
                chk("commit_txn", 80'({ertn_commit, excp_ecode, excp_pc, 32'(cyc)}), 80'(e));
            end
        end
        if (redirect_valid && redirect_ready) begin
            if (redir_q.size() == 0) begin
                chk("redirect_unexpected", 80'(1), 80'(0));
            end else begin
                chk("redirect_txn", 80'(redirect_pc), 80'(redir_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_e     = 0;
        excp_ale_e  = 0;
        excp_sys_e  = 0;
        excp_brk_e  = 0;
        excp_ine_e  = 0;
        int_pending = 0;
        ertn_e      = 0;
    endtask

    // r = {int, ine, sys, brk, ale}
    task automatic drive(input logic [4:0] r, input logic ertn, input logic [GRLEN-1:0] pc);
        valid_e      = 1;
        int_pending  = r[4];
        excp_ine_e   = r[3];
        excp_sys_e   = r[2];
        excp_brk_e   = r[1];
        excp_ale_e   = r[0];
        ertn_e       = ertn;
        ifu_exu_pc_e = pc;
    endtask

    task automatic one_shot(input logic [4:0] r, input logic ertn, input logic [GRLEN-1:0] pc);
        drive(r, ertn, pc);
        tick(1);
        idle_inputs();
        tick(FLUSH_CYC + 4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset          = 1;
        idle_inputs();
        ifu_exu_pc_e   = '0;
        crmd_ie        = 0;
        csr_eentry     = 32'h1c008000;
        csr_era        = 32'h1c000404;
        redirect_ready = 1;
        tick(3);
        reset = 0;
        tick(2);

        // single ALE, then multi-request priority
        one_shot(5'b00001, 0, 32'h1c000010);
        one_shot(5'b00111, 0, 32'h1c000020);

        // interrupt gated by CRMD.IE, then taken once enabled
        drive(5'b10000, 0, 32'h1c000030);
        tick(3);
        crmd_ie = 1;
        tick(1);
        idle_inputs();
        tick(FLUSH_CYC + 4);
        crmd_ie = 0;

        // ERTN alone, then ERTN with INE
        one_shot(5'b00000, 1, 32'h1c000040);
        one_shot(5'b01000, 1, 32'h1c000050);

        // stalled redirect with requests arriving meanwhile
        redirect_ready = 0;
        drive(5'b00001, 0, 32'h1c000060);
        tick(1);
        drive(5'b00100, 1, 32'h1c000064);
        tick(FLUSH_CYC + 5);
        idle_inputs();
        redirect_ready = 1;
        tick(FLUSH_CYC + 4);

        // reset during FLUSH
        drive(5'b00001, 0, 32'h1c000070);
        tick(1);
        idle_inputs();
        reset = 1;
        tick(1);
        reset = 0;
        tick(3);

        // reset during REDIR
        redirect_ready = 0;
        drive(5'b00001, 0, 32'h1c000080);
        tick(1);
        idle_inputs();
        tick(FLUSH_CYC + 2);
        reset = 1;
        tick(1);
        reset = 0;
        redirect_ready = 1;
        tick(3);
        one_shot(5'b00001, 0, 32'h1c000090);

        // back-to-back ALEs held every cycle
        drive(5'b00001, 0, 32'h1c0000a0);
        tick(6 * (FLUSH_CYC + 2));
        idle_inputs();
        tick(FLUSH_CYC + 4);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            valid_e        = 1'($urandom_range(0, 1));
            excp_ale_e     = ($urandom_range(0, 5) == 0);
            excp_sys_e     = ($urandom_range(0, 5) == 0);
            excp_brk_e     = ($urandom_range(0, 5) == 0);
            excp_ine_e     = ($urandom_range(0, 5) == 0);
            int_pending    = ($urandom_range(0, 7) == 0);
            crmd_ie        = 1'($urandom_range(0, 1));
            ertn_e         = ($urandom_range(0, 4) == 0);
            redirect_ready = ($urandom_range(0, 3) != 0);
            ifu_exu_pc_e   = $urandom;
            csr_eentry     = $urandom;
            csr_era        = $urandom;
            reset          = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        reset = 0;
        idle_inputs();
        redirect_ready = 1;
        tick(FLUSH_CYC + 6);

        chk("commit_q_drained", 80'(exp_q.size()), 80'(0));
        chk("redir_q_drained", 80'(redir_q.size()), 80'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
